// File: rtl/store_buffer_pkg.sv
// store_buffer_pkg: shared entry layout and word-index slice for the store buffer and DM.
package store_buffer_pkg;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int PC_W    = 32;
  localparam int WIDX_HI = 11;
  localparam int WIDX_LO = 2;
  localparam int WIDX_W  = WIDX_HI - WIDX_LO + 1;
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [PC_W-1:0]   pc;
  } sb_entry_t;
  function automatic logic [WIDX_W-1:0] widx(input logic [ADDR_W-1:0] a);
    return a[WIDX_HI:WIDX_LO];
  endfunction
endpackage

// File: rtl/store_buffer_fwd_match.sv
// sb_fwd_match: finds the youngest valid entry whose word index equals the load's word index.
module sb_fwd_match
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic [DEPTH-1:0]             vld_i,
  input  logic [DEPTH-1:0][WIDX_W-1:0] widx_i,
  input  logic [PTR_W-1:0]             rd_ptr_i,
  input  logic [WIDX_W-1:0]            ld_widx_i,
  output logic                         hit_o,
  output logic [PTR_W-1:0]             idx_o
);
  logic [PTR_W-1:0] slot;
  // Walk oldest to youngest so the last match seen is the youngest.
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    slot = '0;
    for (int k = 0; k < DEPTH; k++) begin
      slot = rd_ptr_i + PTR_W'(k);
      if (vld_i[slot] && widx_i[slot] == ld_widx_i) begin
        hit_o = 1'b1;
        idx_o = slot;
      end
    end
  end
endmodule

// File: rtl/store_buffer.sv
// store_buffer: word-store FIFO draining into DM, with youngest-match load forwarding.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        st_valid,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_wdata,
  input  logic [31:0] st_pc,
  output logic        st_full,
  input  logic [31:0] ld_addr,
  output logic        ld_hit,
  output logic [31:0] ld_data,
  input  logic        dm_ready,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wd,
  output logic [31:0] dm_pc,
  output logic        empty,
  output logic        overflow
);
  localparam int CW = PTR_W + 1;
  sb_entry_t ent_q [DEPTH];
  sb_entry_t head;
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, hit_idx;
  logic [CW-1:0] count_q, count_d;
  logic overflow_q, overflow_d, push, pop;
  logic [DEPTH-1:0][WIDX_W-1:0] widx_v;
  logic unused_ld_bits;
  assign unused_ld_bits = ^{ld_addr[31:WIDX_HI+1], ld_addr[WIDX_LO-1:0]};
  assign empty = count_q == '0;
  assign st_full = count_q == CW'(DEPTH);
  assign pop = !empty && dm_ready;
  assign push = st_valid && (!st_full || pop);
  assign dm_we = pop;
  assign head = empty ? '0 : ent_q[rd_ptr_q];
  assign dm_addr = head.addr;
  assign dm_wd = head.wdata;
  assign dm_pc = head.pc;
  assign overflow = overflow_q;
  always_comb begin
    widx_v = '0;
    for (int i = 0; i < DEPTH; i++) widx_v[i] = widx(ent_q[i].addr);
  end
  sb_fwd_match #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_match (
    .vld_i    (vld_q),
    .widx_i   (widx_v),
    .rd_ptr_i (rd_ptr_q),
    .ld_widx_i(ld_addr[WIDX_HI:WIDX_LO]),
    .hit_o    (ld_hit),
    .idx_o    (hit_idx)
  );
  assign ld_data = ld_hit ? ent_q[hit_idx].wdata : '0;
  // On a full push+pop both pointers hit the same slot; the push must win the valid bit.
  always_comb begin
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    count_d = count_q + CW'(push) - CW'(pop);
    overflow_d = overflow_q | (st_valid & !push);
    vld_d = vld_q;
    if (pop) vld_d[rd_ptr_q] = 1'b0;
    if (push) vld_d[wr_ptr_q] = 1'b1;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q <= '0;
      vld_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q <= count_d;
      vld_q <= vld_d;
      overflow_q <= overflow_d;
      if (push) ent_q[wr_ptr_q] <= '{addr: st_addr, wdata: st_wdata, pc: st_pc};
    end
  end
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: randomized and directed stimulus against a queue-based store buffer model.
module tb_store_buffer;
  localparam int DEPTH = 4;
  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] p;
  } st_t;
  logic clk = 0, reset = 1, st_valid = 0, dm_ready = 0;
  logic [31:0] st_addr = 0, st_wdata = 0, st_pc = 0, ld_addr = 0;
  logic st_full, ld_hit, dm_we, empty, overflow;
  logic [31:0] ld_data, dm_addr, dm_wd, dm_pc;
  int n_cmp = 0, n_bad = 0;
  st_t mq[$];
  st_t exp_wr[$];
  st_t m_s, w_s;
  bit armed = 0, ovf = 0, m_hit, m_pop, m_full;
  logic [31:0] m_fd;

  store_buffer #(.DEPTH(DEPTH), .PTR_W(2)) dut (
    .clk(clk), .reset(reset), .st_valid(st_valid), .st_addr(st_addr),
    .st_wdata(st_wdata), .st_pc(st_pc), .st_full(st_full), .ld_addr(ld_addr),
    .ld_hit(ld_hit), .ld_data(ld_data), .dm_ready(dm_ready), .dm_we(dm_we),
    .dm_addr(dm_addr), .dm_wd(dm_wd), .dm_pc(dm_pc), .empty(empty), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", nm, act, want);
    end
  endtask

  // Reference: the buffer is just an ordered list of accepted stores.
  always @(negedge clk) begin
    if (armed) begin
      m_full = mq.size() == DEPTH;
      m_pop = mq.size() != 0 && dm_ready;
      m_hit = 0;
      m_fd = 0;
      for (int i = mq.size() - 1; i >= 0; i--) begin
        m_s = mq[i];
        if (!m_hit && m_s.a[11:2] == ld_addr[11:2]) begin
          m_hit = 1;
          m_fd = m_s.d;
        end
      end
      chk("empty", empty, mq.size() == 0);
      chk("st_full", st_full, m_full);
      chk("overflow", overflow, ovf);
      chk("dm_we", dm_we, m_pop);
      m_s = mq.size() != 0 ? mq[0] : '{0, 0, 0};
      chk("dm_addr", dm_addr, m_s.a);
      chk("dm_wd", dm_wd, m_s.d);
      chk("dm_pc", dm_pc, m_s.p);
      chk("ld_hit", ld_hit, m_hit);
      chk("ld_data", ld_data, m_fd);
    end
    if (reset) begin
      mq.delete();
      exp_wr.delete();
      ovf = 0;
      armed = 1;
    end else if (armed) begin
      if (m_pop) void'(mq.pop_front());
      if (st_valid && (!m_full || m_pop)) begin
        mq.push_back('{st_addr, st_wdata, st_pc});
        exp_wr.push_back('{st_addr, st_wdata, st_pc});
      end else if (st_valid) ovf = 1;
    end
  end

  // Scoreboard monitor: every DM write must be the oldest outstanding accepted store.
  always @(negedge clk) begin
    if (armed && dm_we === 1'b1) begin
      if (exp_wr.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL dm_write: got write to %h required no write", dm_addr);
      end else begin
        w_s = exp_wr.pop_front();
        chk("wr_addr", dm_addr, w_s.a);
        chk("wr_data", dm_wd, w_s.d);
        chk("wr_pc", dm_pc, w_s.p);
      end
    end
  end

  task automatic cyc(input logic v, input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] p, input logic rdy, input logic [31:0] la);
    @(posedge clk);
    #1;
    reset = 0;
    st_valid = v;
    st_addr = a;
    st_wdata = d;
    st_pc = p;
    dm_ready = rdy;
    ld_addr = la;
  endtask

  task automatic rst();
    @(posedge clk);
    #1;
    reset = 1;
    st_valid = 0;
    dm_ready = 0;
  endtask

  task automatic idle(input logic rdy, input logic [31:0] la);
    cyc(0, 0, 0, 0, rdy, la);
  endtask

  logic [31:0] ra, rl;

  initial begin
    rst();
    rst();
    for (int i = 0; i < 3; i++) cyc(1, 32'h200 + 32'(i * 4), $urandom, $urandom, 0, 0);
    rst();
    idle(1, 0);
    @(negedge clk);
    chk("rst_empty", empty, 1);
    chk("rst_dm_we", dm_we, 0);
    repeat (3) idle(1, 0);
    cyc(1, 32'h10, 32'h1234_5678, 32'h3000, 1, 0);
    idle(1, 0);
    @(negedge clk);
    chk("basic_we", dm_we, 1);
    chk("basic_addr", dm_addr, 32'h10);
    chk("basic_wd", dm_wd, 32'h1234_5678);
    chk("basic_pc", dm_pc, 32'h3000);
    idle(1, 0);
    @(negedge clk);
    chk("basic_empty", empty, 1);
    for (int i = 0; i < 4; i++) cyc(1, 32'(i * 4), $urandom, $urandom, 0, 0);
    idle(0, 0);
    @(negedge clk);
    chk("fill_full", st_full, 1);
    cyc(1, 32'h40, $urandom, $urandom, 1, 0);
    @(negedge clk);
    chk("pp_head", dm_addr, 32'h0);
    idle(0, 0);
    @(negedge clk);
    chk("pp_full", st_full, 1);
    chk("pp_ovf", overflow, 0);
    cyc(1, 32'h20, $urandom, $urandom, 0, 0);
    idle(0, 0);
    @(negedge clk);
    chk("drop_ovf", overflow, 1);
    repeat (6) idle(1, 0);
    rst();
    idle(0, 0);
    cyc(1, 32'h100, 32'hAAAA_AAAA, 32'h4000, 0, 0);
    cyc(1, 32'h102, 32'hBBBB_BBBB, 32'h4004, 0, 32'h101);
    @(negedge clk);
    chk("nobypass", ld_data, 32'hAAAA_AAAA);
    idle(0, 32'h101);
    @(negedge clk);
    chk("fwd_hit", ld_hit, 1);
    chk("fwd_data", ld_data, 32'hBBBB_BBBB);
    idle(0, 32'h104);
    @(negedge clk);
    chk("fwd_miss", ld_hit, 0);
    chk("fwd_miss_d", ld_data, 0);
    idle(0, 32'h7101);
    @(negedge clk);
    chk("fwd_hi_ign", ld_hit, 1);
    idle(1, 32'h101);
    idle(1, 32'h101);
    idle(1, 0);
    for (int i = 0; i < 20; i++)
      cyc(i % 2 == 0, 32'h500 + 32'(i * 2), $urandom, $urandom, i % 2 == 1, 32'h500 + 32'(i * 2));
    repeat (4) idle(1, 0);
    @(negedge clk);
    chk("wrap_empty", empty, 1);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) rst();
      else begin
        ra = $urandom;
        ra[11:2] = 10'($urandom_range(0, 7));
        rl = $urandom;
        rl[11:2] = 10'($urandom_range(0, 7));
        cyc($urandom_range(0, 1) == 1, ra, $urandom, $urandom, $urandom_range(0, 9) < 4, rl);
      end
    end
    repeat (8) idle(1, 0);
    @(negedge clk);
    chk("end_empty", empty, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
